// File: rtl/aes_enc_pack.sv
// Shared types and default widths for the AES counter-mode key/sync feeder.
package aes_enc_pack;

    localparam int DEF_DATA_WIDTH_IN_BYTES = 16;
    localparam int DEF_CNT_WIDTH_IN_BYTES  = 4;
    localparam int DEF_DEPTH               = 4;
    localparam int DEF_BLOCKS_WIDTH        = 16;

    // Sequencer FSM: waiting for a request, or playing one out beat by beat.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } sync_key_state_t;

    // One buffered request at the default widths (FIFO word layout, MSB first).
    typedef struct packed {
        logic [8*DEF_DATA_WIDTH_IN_BYTES-1:0] key;
        logic [8*DEF_DATA_WIDTH_IN_BYTES-1:0] sync;
        logic [DEF_BLOCKS_WIDTH-1:0]          num_blocks;
    } sync_key_req_t;

endpackage

// File: rtl/sync_key_fifo.sv
// Generic synchronous first-word-fall-through FIFO with occupancy count.
// A push is refused whenever the FIFO is full, even if a pop happens in the same cycle.
module sync_key_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE    = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE    = {{(AW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == FULL_COUNT);
    assign empty     = (count_r == {(AW+1){1'b0}});
    assign count     = count_r;
    assign rd_data   = mem_r[rd_ptr_r];
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Storage array: written on an accepted push; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/sync_key_sequencer.sv
// Key/sync feeder for the counter-mode AES core: buffers {key, sync, block count}
// requests and plays each out as per-block {key, sync} beats, bumping the counter
// field of sync every beat and flagging the final beat of each request.
module sync_key_sequencer
    import aes_enc_pack::*;
#(
    parameter int DATA_WIDTH_IN_BYTES = DEF_DATA_WIDTH_IN_BYTES,
    parameter int CNT_WIDTH_IN_BYTES  = DEF_CNT_WIDTH_IN_BYTES,
    parameter int DEPTH               = DEF_DEPTH,
    parameter int BLOCKS_WIDTH        = DEF_BLOCKS_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [8*DATA_WIDTH_IN_BYTES-1:0] in_key,
    input  logic [8*DATA_WIDTH_IN_BYTES-1:0] in_sync,
    input  logic [BLOCKS_WIDTH-1:0]          in_num_blocks,
    input  logic                             in_valid,
    output logic                             in_rdy,
    output logic [8*DATA_WIDTH_IN_BYTES-1:0] out_key,
    output logic [8*DATA_WIDTH_IN_BYTES-1:0] out_sync,
    output logic                             out_last,
    output logic                             out_valid,
    input  logic                             out_rdy,
    output logic [$clog2(DEPTH):0]           pending,
    output logic                             zero_err
);

    localparam int DW   = 8*DATA_WIDTH_IN_BYTES;
    localparam int CW   = 8*CNT_WIDTH_IN_BYTES;
    localparam int FW   = 2*DW + BLOCKS_WIDTH;
    localparam int CNTW = $clog2(DEPTH) + 1;

    // Counter field = low CW bits of sync; the mask keeps the carry out of the IV.
    localparam logic [DW-1:0]           CNT_MASK = {DW{1'b1}} >> (DW - CW);
    localparam logic [DW-1:0]           SYNC_ONE = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [BLOCKS_WIDTH-1:0] BLK_ZERO = {BLOCKS_WIDTH{1'b0}};
    localparam logic [BLOCKS_WIDTH-1:0] BLK_ONE  = {{(BLOCKS_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [BLOCKS_WIDTH-1:0] BLK_TWO  = {{(BLOCKS_WIDTH-2){1'b0}}, 2'b10};

    // Increment only the counter field, modulo 2^CW; upper bytes pass through.
    function automatic logic [DW-1:0] next_sync(input logic [DW-1:0] s);
        return (s & ~CNT_MASK) | ((s + SYNC_ONE) & CNT_MASK);
    endfunction

    logic [FW-1:0]           fifo_rd_data_s;
    logic                    fifo_full_s;
    logic                    fifo_empty_s;
    logic [CNTW-1:0]         fifo_count_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    load_s;
    logic                    zero_s;
    logic [DW-1:0]           head_key_s;
    logic [DW-1:0]           head_sync_s;
    logic [BLOCKS_WIDTH-1:0] head_blocks_s;

    sync_key_state_t         state_r;
    logic [DW-1:0]           key_r;
    logic [DW-1:0]           sync_r;
    logic [BLOCKS_WIDTH-1:0] remaining_r;
    logic                    last_r;
    logic                    valid_r;
    logic                    zero_err_r;

    // Ready is held low while reset is asserted, otherwise it only reflects a full buffer.
    assign in_rdy = rst & ~fifo_full_s;
    assign push_s = in_valid & in_rdy;

    assign head_key_s    = fifo_rd_data_s[FW-1 -: DW];
    assign head_sync_s   = fifo_rd_data_s[BLOCKS_WIDTH +: DW];
    assign head_blocks_s = fifo_rd_data_s[BLOCKS_WIDTH-1:0];

    sync_key_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_s),
        .wr_data ({in_key, in_sync, in_num_blocks}),
        .pop     (pop_s),
        .rd_data (fifo_rd_data_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    // Decide when to take the FIFO head: from IDLE, or chained onto a consumed last beat.
    always_comb begin
        pop_s  = 1'b0;
        load_s = 1'b0;
        zero_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s = 1'b1;
                    if (head_blocks_s == BLK_ZERO) begin
                        zero_s = 1'b1;
                    end else begin
                        load_s = 1'b1;
                    end
                end else begin
                    pop_s = 1'b0;
                end
            end
            STREAM: begin
                // A zero-length head is left for IDLE so the error pulse has one home.
                if (out_rdy && last_r && !fifo_empty_s && (head_blocks_s != BLK_ZERO)) begin
                    pop_s  = 1'b1;
                    load_s = 1'b1;
                end else begin
                    pop_s = 1'b0;
                end
            end
            default: begin
                pop_s  = 1'b0;
                load_s = 1'b0;
                zero_s = 1'b0;
            end
        endcase
    end

    // FSM, active request registers and per-beat counter advance; outputs hold during stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            key_r       <= {DW{1'b0}};
            sync_r      <= {DW{1'b0}};
            remaining_r <= BLK_ZERO;
            last_r      <= 1'b0;
            valid_r     <= 1'b0;
            zero_err_r  <= 1'b0;
        end else begin
            zero_err_r <= zero_s;
            if (load_s) begin
                state_r     <= STREAM;
                key_r       <= head_key_s;
                sync_r      <= head_sync_s;
                remaining_r <= head_blocks_s;
                last_r      <= (head_blocks_s == BLK_ONE);
                valid_r     <= 1'b1;
            end else if ((state_r == STREAM) && out_rdy) begin
                if (last_r) begin
                    state_r <= IDLE;
                    last_r  <= 1'b0;
                    valid_r <= 1'b0;
                end else begin
                    sync_r      <= next_sync(sync_r);
                    remaining_r <= remaining_r - BLK_ONE;
                    last_r      <= (remaining_r == BLK_TWO);
                end
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign out_key   = key_r;
    assign out_sync  = sync_r;
    assign out_last  = last_r;
    assign out_valid = valid_r;
    assign pending   = fifo_count_s;
    assign zero_err  = zero_err_r;

endmodule

// File: tb/tb_sync_key_sequencer.sv
// Directed self-checking bench for sync_key_sequencer (default instance plus a
// full-width counter instance).
module tb_sync_key_sequencer;

    logic         clk;
    logic         rst;
    logic [127:0] in_key, in_sync;
    logic [15:0]  in_num_blocks;
    logic         in_valid, in_rdy;
    logic [127:0] out_key, out_sync;
    logic         out_last, out_valid, out_rdy;
    logic [2:0]   pending;
    logic         zero_err;

    logic [127:0] in_key2, in_sync2;
    logic [15:0]  in_num_blocks2;
    logic         in_valid2, in_rdy2;
    logic [127:0] out_key2, out_sync2;
    logic         out_last2, out_valid2, out_rdy2;
    logic [2:0]   pending2;
    logic         zero_err2;

    typedef struct packed {
        logic [127:0] key;
        logic [127:0] sync;
        logic         last;
    } beat_t;

    beat_t        exp_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;
    int           beat_cnt = 0;
    int           zero_cnt = 0;
    logic         stall_prev = 1'b0;
    logic [127:0] hold_key, hold_sync;

    sync_key_sequencer dut (
        .clk(clk), .rst(rst),
        .in_key(in_key), .in_sync(in_sync), .in_num_blocks(in_num_blocks),
        .in_valid(in_valid), .in_rdy(in_rdy),
        .out_key(out_key), .out_sync(out_sync), .out_last(out_last),
        .out_valid(out_valid), .out_rdy(out_rdy),
        .pending(pending), .zero_err(zero_err)
    );

    sync_key_sequencer #(.CNT_WIDTH_IN_BYTES(16)) dut_full (
        .clk(clk), .rst(rst),
        .in_key(in_key2), .in_sync(in_sync2), .in_num_blocks(in_num_blocks2),
        .in_valid(in_valid2), .in_rdy(in_rdy2),
        .out_key(out_key2), .out_sync(out_sync2), .out_last(out_last2),
        .out_valid(out_valid2), .out_rdy(out_rdy2),
        .pending(pending2), .zero_err(zero_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic push_beat(input logic [127:0] k, input logic [127:0] s, input logic l);
        beat_t b;
        b.key = k; b.sync = s; b.last = l;
        exp_q.push_back(b);
    endtask

    // Expected beats for a request with a 32-bit counter field.
    task automatic exp_push(input logic [127:0] k, input logic [127:0] s, input int nb);
        logic [31:0] lo;
        for (int i = 0; i < nb; i++) begin
            lo = s[31:0] + 32'(i);
            push_beat(k, {s[127:32], lo}, (i == nb - 1));
        end
    endtask

    task automatic send(input logic [127:0] k, input logic [127:0] s, input logic [15:0] nb);
        int   guard;
        logic took;
        in_key = k; in_sync = s; in_num_blocks = nb; in_valid = 1'b1;
        guard = 0; took = 1'b0;
        while (!took && guard < 100) begin
            @(negedge clk);
            took = in_rdy;
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        check_eq("send_accept", 128'(took), 128'd1);
    endtask

    task automatic wait_drain(input int bound, output int cyc);
        cyc = 0;
        while (exp_q.size() > 0 && cyc < bound) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq("drain", 128'(exp_q.size()), 128'd0);
    endtask

    // Beat monitor: scoreboard compare on handshake, stability check across stalls.
    always @(negedge clk) begin
        beat_t b;
        if (rst) begin
            if (zero_err) zero_cnt++;
            if (stall_prev) begin
                check_eq("hold_key", out_key, hold_key);
                check_eq("hold_sync", out_sync, hold_sync);
            end
            stall_prev = out_valid && !out_rdy;
            hold_key   = out_key;
            hold_sync  = out_sync;
            if (out_valid && out_rdy) begin
                beat_cnt++;
                check_eq("beat_expected", 128'(exp_q.size() > 0), 128'd1);
                if (exp_q.size() > 0) begin
                    b = exp_q.pop_front();
                    check_eq("beat_key", out_key, b.key);
                    check_eq("beat_sync", out_sync, b.sync);
                    check_eq("beat_last", 128'(out_last), 128'(b.last));
                end
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, b0;
        logic [127:0] k1, s1, ones;
        rst = 1'b1; in_valid = 1'b0; out_rdy = 1'b0;
        in_key = '0; in_sync = '0; in_num_blocks = '0;
        in_valid2 = 1'b0; out_rdy2 = 1'b0;
        in_key2 = '0; in_sync2 = '0; in_num_blocks2 = '0;
        #3 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check_eq("rst_valid", 128'(out_valid), 128'd0);
        check_eq("rst_in_rdy", 128'(in_rdy), 128'd0);
        check_eq("rst_pending", 128'(pending), 128'd0);
        check_eq("rst_key", out_key, 128'd0);
        check_eq("rst_sync", out_sync, 128'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check_eq("post_rst_in_rdy", 128'(in_rdy), 128'd1);

        // Test 1: counter wrap within the 32-bit field, latency 2
        k1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        s1 = {96'hCAFEBABE_DEADBEEF_01234567, 32'hFFFFFFFE};
        push_beat(k1, {96'hCAFEBABE_DEADBEEF_01234567, 32'hFFFFFFFE}, 1'b0);
        push_beat(k1, {96'hCAFEBABE_DEADBEEF_01234567, 32'hFFFFFFFF}, 1'b0);
        push_beat(k1, {96'hCAFEBABE_DEADBEEF_01234567, 32'h00000000}, 1'b1);
        out_rdy = 1'b1;
        @(posedge clk); #1;
        b0 = beat_cnt;
        send(k1, s1, 16'd3);
        @(negedge clk);
        check_eq("lat_idle", 128'(out_valid), 128'd0);
        @(negedge clk);
        check_eq("lat_first", 128'(out_valid), 128'd1);
        wait_drain(50, cyc);
        check_eq("t1_beats", 128'(beat_cnt - b0), 128'd3);

        // Test 2: fill buffer with out_rdy low, then drain without bubbles
        out_rdy = 1'b0;
        @(posedge clk); #1;
        b0 = beat_cnt;
        exp_push(128'hA0, {96'h1, 32'd10}, 2);
        exp_push(128'hA1, {96'h2, 32'd20}, 1);
        exp_push(128'hA2, {96'h3, 32'd30}, 3);
        exp_push(128'hA3, {96'h4, 32'd40}, 2);
        exp_push(128'hA4, {96'h5, 32'd50}, 1);
        send(128'hA0, {96'h1, 32'd10}, 16'd2);
        send(128'hA1, {96'h2, 32'd20}, 16'd1);
        send(128'hA2, {96'h3, 32'd30}, 16'd3);
        send(128'hA3, {96'h4, 32'd40}, 16'd2);
        send(128'hA4, {96'h5, 32'd50}, 16'd1);
        check_eq("full_pending", 128'(pending), 128'd4);
        check_eq("full_in_rdy", 128'(in_rdy), 128'd0);
        in_key = 128'hBAD; in_sync = '0; in_num_blocks = 16'd1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("held_in_rdy", 128'(in_rdy), 128'd0);
            check_eq("held_pending", 128'(pending), 128'd4);
        end
        @(posedge clk); #1 in_valid = 1'b0;
        out_rdy = 1'b1;
        wait_drain(100, cyc);
        check_eq("no_bubble_cycles", 128'(cyc), 128'd9);
        check_eq("t2_beats", 128'(beat_cnt - b0), 128'd9);

        // Test 3: random back-pressure over 8 beats, counters 0..7
        out_rdy = 1'b0;
        @(posedge clk); #1;
        b0 = beat_cnt;
        exp_push(128'h77, {96'hFEED, 32'd0}, 8);
        send(128'h77, {96'hFEED, 32'd0}, 16'd8);
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 300) begin
            out_rdy = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            cyc++;
        end
        out_rdy = 1'b1;
        wait_drain(50, cyc);
        check_eq("t3_beats", 128'(beat_cnt - b0), 128'd8);

        // Test 4: zero-length request between two 2-beat requests
        @(posedge clk); #1;
        b0 = beat_cnt; zero_cnt = 0;
        exp_push(128'hC1, {96'hC, 32'd100}, 2);
        exp_push(128'hC3, {96'hD, 32'd200}, 2);
        send(128'hC1, {96'hC, 32'd100}, 16'd2);
        send(128'hC2, {96'hE, 32'd300}, 16'd0);
        send(128'hC3, {96'hD, 32'd200}, 16'd2);
        wait_drain(100, cyc);
        repeat (3) @(posedge clk);
        #1;
        check_eq("zero_err_pulses", 128'(zero_cnt), 128'd1);
        check_eq("t4_beats", 128'(beat_cnt - b0), 128'd4);

        // Test 5: reset in the middle of a 5-beat request
        exp_push(128'hD5, {96'hAB, 32'd0}, 5);
        send(128'hD5, {96'hAB, 32'd0}, 16'd5);
        send(128'hD6, {96'hAC, 32'd0}, 16'd2);
        @(posedge clk); #1;
        check_eq("mid_beat2_sync", out_sync, {96'hAB, 32'd1});
        check_eq("mid_pending", 128'(pending), 128'd1);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_valid", 128'(out_valid), 128'd0);
        check_eq("mid_rst_key", out_key, 128'd0);
        check_eq("mid_rst_sync", out_sync, 128'd0);
        check_eq("mid_rst_last", 128'(out_last), 128'd0);
        check_eq("mid_rst_pending", 128'(pending), 128'd0);
        check_eq("mid_rst_in_rdy", 128'(in_rdy), 128'd0);
        exp_q.delete();
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        b0 = beat_cnt;
        exp_push(128'hE1, {96'h99, 32'h100}, 2);
        send(128'hE1, {96'h99, 32'h100}, 16'd2);
        wait_drain(50, cyc);
        check_eq("t5_beats", 128'(beat_cnt - b0), 128'd2);

        // Test 6: full-width counter wraps the whole sync
        ones = {128{1'b1}};
        @(posedge clk); #1;
        in_key2 = 128'h5A5A; in_sync2 = ones; in_num_blocks2 = 16'd2;
        in_valid2 = 1'b1; out_rdy2 = 1'b1;
        @(negedge clk);
        check_eq("w_in_rdy", 128'(in_rdy2), 128'd1);
        @(posedge clk); #1 in_valid2 = 1'b0;
        @(negedge clk);
        check_eq("w_lat_idle", 128'(out_valid2), 128'd0);
        @(negedge clk);
        check_eq("w_b1_valid", 128'(out_valid2), 128'd1);
        check_eq("w_b1_sync", out_sync2, ones);
        check_eq("w_b1_last", 128'(out_last2), 128'd0);
        @(negedge clk);
        check_eq("w_b2_sync", out_sync2, 128'd0);
        check_eq("w_b2_key", out_key2, 128'h5A5A);
        check_eq("w_b2_last", 128'(out_last2), 128'd1);
        @(negedge clk);
        check_eq("w_done_valid", 128'(out_valid2), 128'd0);
        check_eq("w_pending", 128'(pending2), 128'd0);
        check_eq("w_zero_err", 128'(zero_err2), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
